// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU op sequencer.
//   state_t    : sequencer FSM states
//   alu_ctrl_t : ALU control vector {inv_a, inv_b, cin, or_en, fc}
//   op_class_t : op-class flags produced by the decoder
//   CTRL_*     : control vectors, OP_*: {alt,funct3} op codes
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic inv_a;
        logic inv_b;
        logic cin;
        logic or_en;
        logic fc;
    } alu_ctrl_t;

    typedef struct packed {
        logic is_shift;
        logic is_slt;
        logic is_signed;
        logic is_left;
    } op_class_t;

    localparam alu_ctrl_t CTRL_ADD = 5'b00000;
    localparam alu_ctrl_t CTRL_SUB = 5'b01100;
    localparam alu_ctrl_t CTRL_AND = 5'b11011;
    localparam alu_ctrl_t CTRL_OR  = 5'b00010;
    localparam alu_ctrl_t CTRL_XOR = 5'b01001;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response and ALU-side signals of the op sequencer.
//   master : issue side + external ALU (drives requests, RspReady, ALU results)
//   slave  : the sequencer (drives ReqReady, response and ALU operands/control)
interface alu_op_sequencer_if #(
    parameter int unsigned Width = 32
);
    logic             ReqValid;
    logic             ReqReady;
    logic [3:0]       ReqOp;
    logic [Width-1:0] ReqA;
    logic [Width-1:0] ReqB;
    logic             Flush;
    logic             RspValid;
    logic             RspReady;
    logic [Width-1:0] RspData;
    logic [Width-1:0] AluInA;
    logic [Width-1:0] AluInB;
    logic             AluCarryIn;
    logic             AluOr;
    logic             AluFloodCarry;
    logic             AluInvertA;
    logic             AluInvertB;
    logic [Width-1:0] AluOutC;
    logic             AluCarryOut;

    modport master (
        output ReqValid, ReqOp, ReqA, ReqB, Flush, RspReady, AluOutC, AluCarryOut,
        input  ReqReady, RspValid, RspData, AluInA, AluInB,
               AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB
    );

    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB, Flush, RspReady, AluOutC, AluCarryOut,
        output ReqReady, RspValid, RspData, AluInA, AluInB,
               AluCarryIn, AluOr, AluFloodCarry, AluInvertA, AluInvertB
    );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational op decoder: {alt,funct3} -> ALU control vector and op-class flags.
//   op_i     : {alt,funct3}
//   ctrl_c   : ALU control vector for the single-cycle path
//   cls_c    : shift / slt / signed / left-shift flags
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op_i,
    output alu_ctrl_t  ctrl_c,
    output op_class_t  cls_c
);

    logic       alt;
    logic [2:0] funct3;

    assign alt    = op_i[3];
    assign funct3 = op_i[2:0];

    // alt only matters for funct3 000 (ADD/SUB) and 101 (SRL/SRA)
    always_comb begin
        ctrl_c = CTRL_ADD;
        cls_c  = '0;
        case (funct3)
            3'b000: ctrl_c = alt ? CTRL_SUB : CTRL_ADD;
            3'b001: begin
                cls_c.is_shift = 1'b1;
                cls_c.is_left  = 1'b1;
            end
            3'b010: begin
                ctrl_c           = CTRL_SUB;
                cls_c.is_slt     = 1'b1;
                cls_c.is_signed  = 1'b1;
            end
            3'b011: begin
                ctrl_c       = CTRL_SUB;
                cls_c.is_slt = 1'b1;
            end
            3'b100: ctrl_c = CTRL_XOR;
            3'b101: begin
                cls_c.is_shift  = 1'b1;
                cls_c.is_signed = alt;
            end
            3'b110: ctrl_c = CTRL_OR;
            3'b111: ctrl_c = CTRL_AND;
            default: ctrl_c = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the shared bit-sliced ALU for RV32EC OP/OP-IMM integer ops,
// returning one result per accepted request. Shifts run one bit per cycle.
//   Clock, Reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : ReqValid/ReqReady/ReqOp/ReqA/ReqB request, Flush abort,
//                    RspValid/RspReady/RspData response, Alu* operands/control
//                    out, AluOutC/AluCarryOut from the external ALU
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    alu_op_sequencer_if.slave bus
);

    localparam int unsigned ShW = $clog2(Width);

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [Width-1:0] rsp_data_q, rsp_data_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [ShW-1:0]   cnt_q, cnt_d;
    logic             b_msb_q, b_msb_d;
    op_class_t        cls_q, cls_d;
    logic [Width-1:0] alu_a_q, alu_a_d;
    logic [Width-1:0] alu_b_q, alu_b_d;
    alu_ctrl_t        alu_ctrl_q, alu_ctrl_d;

    alu_ctrl_t        dec_ctrl_c;
    op_class_t        dec_cls_c;
    logic [ShW-1:0]   shamt_c;
    logic [Width-1:0] acc_nxt_c;
    logic             slt_lt_c;
    logic [Width-1:0] exec_res_c;

    alu_op_decode u_dec (
        .op_i   (bus.ReqOp),
        .ctrl_c (dec_ctrl_c),
        .cls_c  (dec_cls_c)
    );

    assign shamt_c = bus.ReqB[ShW-1:0];

    // Left shift doubles via the ALU; right shifts are done locally
    assign acc_nxt_c = cls_q.is_left ? bus.AluOutC
                                     : {cls_q.is_signed & acc_q[Width-1], acc_q[Width-1:1]};

    // Signs differ: the negative operand is smaller; otherwise borrow of A-B decides
    assign slt_lt_c = (cls_q.is_signed && (acc_q[Width-1] != b_msb_q)) ? acc_q[Width-1]
                                                                      : ~bus.AluCarryOut;

    always_comb begin
        if (cls_q.is_slt)        exec_res_c = Width'(slt_lt_c);
        else if (cls_q.is_shift) exec_res_c = acc_q;
        else                     exec_res_c = bus.AluOutC;
    end

    // Next-state and registered-output logic; ALU drive is registered for the next state
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        b_msb_d     = b_msb_q;
        cls_d       = cls_q;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_ctrl_d  = CTRL_ADD;

        case (state_q)
            IDLE: begin
                if (bus.ReqValid && ready_q) begin
                    ready_d = 1'b0;
                    acc_d   = bus.ReqA;
                    cnt_d   = shamt_c;
                    b_msb_d = bus.ReqB[Width-1];
                    cls_d   = dec_cls_c;
                    if (dec_cls_c.is_shift && (shamt_c != '0)) begin
                        state_d = SHIFT;
                        if (dec_cls_c.is_left) begin
                            alu_a_d = bus.ReqA;
                            alu_b_d = bus.ReqA;
                        end
                    end else begin
                        state_d    = EXEC;
                        alu_a_d    = bus.ReqA;
                        alu_b_d    = bus.ReqB;
                        alu_ctrl_d = dec_ctrl_c;
                    end
                end
            end
            EXEC: begin
                rsp_data_d  = exec_res_c;
                rsp_valid_d = 1'b1;
                state_d     = DONE;
            end
            SHIFT: begin
                acc_d = acc_nxt_c;
                cnt_d = cnt_q - ShW'(1);
                if (cnt_q == ShW'(1)) begin
                    rsp_data_d  = acc_nxt_c;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (cls_q.is_left) begin
                    alu_a_d = acc_nxt_c;
                    alu_b_d = acc_nxt_c;
                end
            end
            DONE: begin
                if (bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush beats everything, including acceptance and RspReady
        if (bus.Flush) begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b0;
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_ctrl_d  = CTRL_ADD;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            b_msb_q     <= 1'b0;
            cls_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= CTRL_ADD;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            b_msb_q     <= b_msb_d;
            cls_q       <= cls_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    assign bus.ReqReady      = ready_q;
    assign bus.RspValid      = rsp_valid_q;
    assign bus.RspData       = rsp_data_q;
    assign bus.AluInA        = alu_a_q;
    assign bus.AluInB        = alu_b_q;
    assign bus.AluInvertA    = alu_ctrl_q.inv_a;
    assign bus.AluInvertB    = alu_ctrl_q.inv_b;
    assign bus.AluCarryIn    = alu_ctrl_q.cin;
    assign bus.AluOr         = alu_ctrl_q.or_en;
    assign bus.AluFloodCarry = alu_ctrl_q.fc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: external ALU model, transaction-level reference
// model, per-cycle compare, directed cases and a random soak.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned W = 32;

    logic Clock;
    logic Reset_n;
    int   n_checks;
    int   n_errors;

    alu_op_sequencer_if #(.Width(W)) bus ();

    alu_op_sequencer #(.Width(W)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- external bit-sliced ALU ----------------
    logic [W-1:0] alu_ea, alu_eb, alu_p;
    logic [W:0]   alu_sum;
    always_comb begin
        alu_ea  = bus.AluInvertA ? ~bus.AluInA : bus.AluInA;
        alu_eb  = bus.AluInvertB ? ~bus.AluInB : bus.AluInB;
        alu_p   = bus.AluOr ? (alu_ea | alu_eb) : (alu_ea ^ alu_eb);
        alu_sum = {1'b0, alu_ea} + {1'b0, alu_eb} + (W+1)'(bus.AluCarryIn);
        if (bus.AluOr || bus.AluFloodCarry) begin
            // every slice sees carry-in = FloodCarry, no propagation
            bus.AluOutC     = bus.AluFloodCarry ? ~alu_p : alu_p;
            bus.AluCarryOut = bus.AluFloodCarry;
        end else begin
            bus.AluOutC     = alu_sum[W-1:0];
            bus.AluCarryOut = alu_sum[W];
        end
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ISA-level result of one op
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op[2:0])
            3'b000: return op[3] ? a - b : a + b;
            3'b001: return a << sh;
            3'b010: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b011: return (a < b) ? W'(1) : W'(0);
            3'b100: return a ^ b;
            3'b101: return op[3] ? W'($signed(a) >>> sh) : a >> sh;
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    // cycles between acceptance and the response appearing
    function automatic int busy_cycles(input logic [3:0] op, input logic [W-1:0] b);
        if ((op[2:0] == 3'b001 || op[2:0] == 3'b101) && b[4:0] != 5'd0) return int'(b[4:0]);
        return 1;
    endfunction

    // ---------------- reference model ----------------
    logic         m_ready, m_valid;
    logic [W-1:0] m_data, m_exp;
    int           m_busy;
    int           n_accept;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_busy  <= 0;
        end else if (bus.Flush) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_busy  <= 0;
        end else if (m_ready && bus.ReqValid) begin
            m_ready  <= 1'b0;
            m_exp    <= ref_result(bus.ReqOp, bus.ReqA, bus.ReqB);
            m_busy   <= busy_cycles(bus.ReqOp, bus.ReqB);
            n_accept <= n_accept + 1;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1;
                m_data  <= m_exp;
            end
        end else if (m_valid && bus.RspReady) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    // per-cycle compare on the falling edge
    always @(negedge Clock) begin
        chk("req_ready", W'(bus.ReqReady), W'(m_ready));
        chk("rsp_valid", W'(bus.RspValid), W'(m_valid));
        if (m_valid) chk("rsp_data", bus.RspData, m_data);
        if (m_ready || m_valid) begin
            chk("alu_in_a", bus.AluInA, '0);
            chk("alu_in_b", bus.AluInB, '0);
            chk("alu_ctrl", W'({bus.AluInvertA, bus.AluInvertB, bus.AluCarryIn,
                                bus.AluOr, bus.AluFloodCarry}), '0);
        end
    end

    // ---------------- stimulus helpers ----------------
    int edges;

    // Issue one op and wait for its response; caller sets RspReady beforehand
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_edges, input string name);
        @(negedge Clock);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqA     = a;
        bus.ReqB     = b;
        @(posedge Clock);
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        edges = 0;
        while (!bus.RspValid && edges < 100) begin
            @(posedge Clock);
            edges++;
            @(negedge Clock);
        end
        chk({name, "_data"}, bus.RspData, exp);
        chk({name, "_lat"}, W'(edges), W'(exp_edges));
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [W-1:0] held;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        n_accept     = 0;
        Reset_n      = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqOp    = '0;
        bus.ReqA     = '0;
        bus.ReqB     = '0;
        bus.Flush    = 1'b0;
        bus.RspReady = 1'b1;

        // reset state
        repeat (2) @(negedge Clock);
        chk("rst_ready", W'(bus.ReqReady), W'(1));
        chk("rst_valid", W'(bus.RspValid), W'(0));
        chk("rst_data", bus.RspData, '0);
        Reset_n = 1'b1;
        @(negedge Clock);

        // arithmetic and compares
        run_op(OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1, "add_wrap");
        run_op(OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE, 1, "sub");
        run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1, "slt_neg");
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "sltu");
        run_op(OP_SLT,  32'h1234, 32'h1234, 32'd0, 1, "slt_eq");
        run_op(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, "and");
        run_op(OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1, "xor");
        run_op(OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1, "or");
        run_op(4'b1110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1, "or_alt");

        // shifts
        run_op(OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 31, "sll31");
        run_op(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4, "sra4");
        run_op(OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4, "srl4");
        run_op(OP_SLL, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1, "sh0");
        run_op(OP_SRL, 32'h0000_0100, 32'hFFFF_FFE1, 32'h0000_0080, 1, "shamt_mask");

        // backpressure in DONE
        @(negedge Clock);
        bus.RspReady = 1'b0;
        run_op(OP_ADD, 32'd40, 32'd2, 32'd42, 1, "hold");
        held = bus.RspData;
        bus.ReqValid = 1'b1;
        bus.ReqOp    = OP_ADD;
        bus.ReqA     = 32'd1;
        bus.ReqB     = 32'd1;
        repeat (5) begin
            @(negedge Clock);
            chk("hold_valid", W'(bus.RspValid), W'(1));
            chk("hold_data", bus.RspData, held);
            chk("hold_ready", W'(bus.ReqReady), W'(0));
        end
        bus.ReqValid = 1'b0;
        bus.RspReady = 1'b1;
        repeat (3) @(negedge Clock);

        // flush in the 10th shift cycle
        bus.ReqValid = 1'b1;
        bus.ReqOp    = OP_SLL;
        bus.ReqA     = 32'd1;
        bus.ReqB     = 32'd20;
        @(posedge Clock);
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        repeat (9) @(negedge Clock);
        bus.Flush = 1'b1;
        @(negedge Clock);
        bus.Flush = 1'b0;
        chk("flush_ready", W'(bus.ReqReady), W'(1));
        chk("flush_valid", W'(bus.RspValid), W'(0));
        repeat (15) begin
            @(negedge Clock);
            chk("flush_no_rsp", W'(bus.RspValid), W'(0));
        end
        run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "post_flush");

        // asynchronous reset mid-shift
        @(negedge Clock);
        bus.ReqValid = 1'b1;
        bus.ReqOp    = OP_SLL;
        bus.ReqA     = 32'd3;
        bus.ReqB     = 32'd31;
        @(posedge Clock);
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        repeat (5) @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_ready", W'(bus.ReqReady), W'(1));
        chk("arst_valid", W'(bus.RspValid), W'(0));
        chk("arst_data", bus.RspData, '0);
        chk("arst_alu_a", bus.AluInA, '0);
        chk("arst_alu_b", bus.AluInB, '0);
        @(negedge Clock);
        #2 Reset_n = 1'b1;
        @(negedge Clock);
        chk("arst_ready_after", W'(bus.ReqReady), W'(1));
        repeat (40) @(negedge Clock);
        run_op(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, "post_arst");

        // random soak against the model
        n_accept = 0;
        for (int cyc = 0; cyc < 60000 && n_accept < 2000; cyc++) begin
            @(negedge Clock);
            bus.ReqValid = ($urandom_range(0, 3) != 0);
            bus.ReqOp    = 4'($urandom);
            bus.ReqA     = rand_word();
            bus.ReqB     = rand_word();
            bus.RspReady = ($urandom_range(0, 3) != 0);
            bus.Flush    = ($urandom_range(0, 49) == 0);
        end
        @(negedge Clock);
        bus.ReqValid = 1'b0;
        bus.Flush    = 1'b0;
        bus.RspReady = 1'b1;
        repeat (40) @(negedge Clock);
        chk("soak_done", W'(n_accept >= 2000), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
